req_capture_encoder: RTL and testbench
======================================

REQ_CAPTURE_ENCODER -- requirements
Module: req_capture_encoder

Interface
REQ-001 Parameter: EDGE_MODE, default 1, where 1 = capture rising edges of req and 0 = capture req levels.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  8  request lines; bit i = source i.
REQ-005 mask  input  8  bit i = 1 blocks source i from being presented; source i still records pending events.
REQ-006 ready  input  1  consumer accepts the presented code.
REQ-007 code  output  3  binary index of the presented source, registered.
REQ-008 valid  output  1  code is valid, registered.
REQ-009 pending  output  8  pending-event register contents.
REQ-010 overflow  output  1  sticky flag: an event was lost.

Function
REQ-011 The block SHALL keep a sample register req_q and form event = req & ~req_q when EDGE_MODE=1, or event = req when EDGE_MODE=0.
REQ-012 The block SHALL update every cycle: pending <= (pending & ~clr) | event, where clr = one-hot(code) when valid && ready, otherwise 0.
REQ-013 If an event on bit i coincides with acceptance of bit i, the event SHALL win, so bit i stays pending.
REQ-014 overflow SHALL set when an event arrives on a bit that is already pending and is not being cleared that cycle, and SHALL stay set until reset.
REQ-015 The block SHALL use an FSM with two states, IDLE and PRESENT.
REQ-016 In IDLE with candidates = pending & ~mask nonzero, the block SHALL load code with the index of the highest set bit of candidates (bit 7 = highest priority), set valid=1, and enter PRESENT.
REQ-017 In IDLE with candidates = 0, the block SHALL keep valid=0 and hold code unchanged.
REQ-018 In PRESENT, code and valid SHALL hold stable while ready=0, whatever happens on req, mask or pending.
REQ-019 In PRESENT with ready=1, the block SHALL clear the pending bit per REQ-012, drive valid=0 on the next cycle, and return to IDLE.
REQ-020 Throughput is one grant per two cycles minimum, with a guaranteed one-cycle valid=0 bubble between grants.
REQ-021 Latency: req rises before edge k -> pending bit set after edge k -> valid=1 after edge k+1.
REQ-022 Setting mask while in PRESENT SHALL NOT retract valid; mask only gates the next selection.
REQ-023 ready while valid=0 SHALL have no effect.

Reset
REQ-024 With rst_n=0 at a clk edge, the block SHALL set req_q=0, pending=0, code=0, valid=0, overflow=0, and FSM=IDLE, overriding all other updates.
REQ-025 Because req_q resets to 0, a req bit held high at reset release SHALL count as an edge in the first cycle after release.
REQ-026 Reset asserted mid-handshake SHALL drop valid on the same edge, with no grant completed.

Structure
REQ-027 A shared package SHALL hold NUM_REQ=8, CODE_W=3, and the state enum {IDLE, PRESENT}.
REQ-028 The block SHALL instantiate one combinational sub-module, prio_enc_8x3 (8-bit in -> 3-bit highest-set index plus any flag), used for selection.

Verification
REQ-029 Reset: rst_n=0 for 3 cycles with req=8'hFF -> valid=0, code=0, pending=0, overflow=0; after release, pending=8'hFF and then valid=1 with code=7.
REQ-030 Single event: req 8'h00->8'h04 with ready=1 -> valid=1 with code=3'd2 two edges later, pending=8'h00 after accept, valid=0 on the following cycle.
REQ-031 Priority/bubble: req 8'h00->8'h81 with ready=1 -> code=7 for one cycle, valid=0 for one cycle, then code=0 for one cycle.
REQ-032 Backpressure: code=5 presented with ready=0, then bit 7 rises -> code stays 5 and valid stays 1 until ready=1; code=7 appears after the bubble.
REQ-033 Mask: mask=8'h04 and event on bit 2 -> valid stays 0 and pending=8'h04; set mask=8'h00 -> valid=1 with code=2 one edge later.
REQ-034 Overflow/coincidence: bit 1 pulses twice while ready=0 -> overflow=1, pending=8'h02, exactly one grant; an event on bit 1 in the accept cycle -> pending bit 1 stays 1.

Source files
------------

// File: rtl/req_capture_encoder_pkg.sv
// Shared sizes, FSM encoding and helpers for the request capture encoder.
package req_capture_encoder_pkg;

  localparam int NUM_REQ = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // Expand a source index into the pending-bit clear mask.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
    logic [NUM_REQ-1:0] one_s;
    one_s = {{(NUM_REQ-1){1'b0}}, 1'b1};
    return one_s << idx;
  endfunction

endpackage

// File: rtl/req_capture_encoder_prio_enc_8x3.sv
// Combinational 8-to-3 priority encoder: index of the highest set bit, bit 7 wins.
module prio_enc_8x3
  import req_capture_encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] in_vec,
  output logic [CODE_W-1:0]  idx,
  output logic               any
);

  // Scan upward so the highest set bit overwrites lower ones.
  always_comb begin
    idx = {CODE_W{1'b0}};
    any = |in_vec;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_vec[i]) begin
        idx = CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/req_capture_encoder.sv
// Captures request events into a pending register and presents one source
// index at a time through a valid/ready handshake.
module req_capture_encoder
  import req_capture_encoder_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  mask,
  input  logic                ready,
  output logic [CODE_W-1:0]   code,
  output logic                valid,
  output logic [NUM_REQ-1:0]  pending,
  output logic                overflow
);

  logic [NUM_REQ-1:0] req_q_r;
  logic [NUM_REQ-1:0] pending_r;
  logic [CODE_W-1:0]  code_r;
  logic               valid_r;
  logic               overflow_r;
  state_e             state_r;

  logic [NUM_REQ-1:0] event_s;
  logic [NUM_REQ-1:0] clr_s;
  logic [NUM_REQ-1:0] pending_nxt_s;
  logic [NUM_REQ-1:0] candidates_s;
  logic               accept_s;
  logic               lost_s;
  logic [CODE_W-1:0]  sel_idx_s;
  logic               sel_any_s;
  state_e             state_nxt_s;
  logic [CODE_W-1:0]  code_nxt_s;
  logic               valid_nxt_s;

  prio_enc_8x3 u_prio_enc (
    .in_vec (candidates_s),
    .idx    (sel_idx_s),
    .any    (sel_any_s)
  );

  // Event detection, pending update and loss detection. A new event on a bit
  // being accepted wins, so that bit stays pending without counting as lost.
  always_comb begin
    if (EDGE_MODE) begin
      event_s = req & ~req_q_r;
    end else begin
      event_s = req;
    end
    accept_s      = (state_r == PRESENT) && valid_r && ready;
    clr_s         = accept_s ? onehot(code_r) : {NUM_REQ{1'b0}};
    pending_nxt_s = (pending_r & ~clr_s) | event_s;
    lost_s        = |(event_s & pending_r & ~clr_s);
    candidates_s  = pending_r & ~mask;
  end

  // Presentation FSM: mask only gates selection in IDLE, never a live grant.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    valid_nxt_s = valid_r;
    case (state_r)
      IDLE: begin
        if (sel_any_s) begin
          code_nxt_s  = sel_idx_s;
          valid_nxt_s = 1'b1;
          state_nxt_s = PRESENT;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      PRESENT: begin
        if (ready) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State registers; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q_r    <= {NUM_REQ{1'b0}};
      pending_r  <= {NUM_REQ{1'b0}};
      code_r     <= {CODE_W{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      state_r    <= IDLE;
    end else begin
      req_q_r    <= req;
      pending_r  <= pending_nxt_s;
      code_r     <= code_nxt_s;
      valid_r    <= valid_nxt_s;
      overflow_r <= overflow_r | lost_s;
      state_r    <= state_nxt_s;
    end
  end

  assign code     = code_r;
  assign valid    = valid_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_req_capture_encoder.sv
// Directed self-checking bench for req_capture_encoder (edge mode).
module tb_req_capture_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int checks;
  int errors;

  req_capture_encoder #(.EDGE_MODE(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .ready    (ready),
    .code     (code),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_p;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 8'hFF;
    mask   = 8'h00;
    ready  = 1'b0;

    // Reset with all requests high
    repeat (3) tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_pending", 32'(pending), 32'hFF);
    check("rel_valid0", 32'(valid), 32'd0);
    tick();
    check("rel_valid1", 32'(valid), 32'd1);
    check("rel_code7", 32'(code), 32'd7);
    ready = 1'b1;
    exp_p = 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      tick();
      exp_p[i] = 1'b0;
      check("drain_bubble", 32'(valid), 32'd0);
      check("drain_pending", 32'(pending), 32'(exp_p));
      if (i > 0) begin
        tick();
        check("drain_valid", 32'(valid), 32'd1);
        check("drain_code", 32'(code), 32'(i - 1));
      end
    end
    req = 8'h00;
    tick();
    check("idle_valid", 32'(valid), 32'd0);

    // Single event on bit 2
    req = 8'h04;
    tick();
    check("single_pending", 32'(pending), 32'h04);
    check("single_valid0", 32'(valid), 32'd0);
    tick();
    check("single_valid1", 32'(valid), 32'd1);
    check("single_code", 32'(code), 32'd2);
    tick();
    check("single_acc_pending", 32'(pending), 32'h00);
    check("single_acc_valid", 32'(valid), 32'd0);
    tick();
    check("single_after_valid", 32'(valid), 32'd0);
    req = 8'h00;
    tick();

    // Priority and bubble
    req = 8'h81;
    tick();
    check("prio_pending", 32'(pending), 32'h81);
    tick();
    check("prio_valid7", 32'(valid), 32'd1);
    check("prio_code7", 32'(code), 32'd7);
    tick();
    check("prio_bubble", 32'(valid), 32'd0);
    check("prio_pending01", 32'(pending), 32'h01);
    tick();
    check("prio_valid0", 32'(valid), 32'd1);
    check("prio_code0", 32'(code), 32'd0);
    tick();
    check("prio_done", 32'(valid), 32'd0);
    check("prio_done_pending", 32'(pending), 32'h00);
    req = 8'h00;
    tick();

    // Backpressure, with mask raised while presenting
    ready = 1'b0;
    req   = 8'h20;
    tick();
    check("bp_pending", 32'(pending), 32'h20);
    tick();
    check("bp_code5", 32'(code), 32'd5);
    req = 8'hA0;
    tick();
    check("bp_hold_code", 32'(code), 32'd5);
    check("bp_hold_valid", 32'(valid), 32'd1);
    check("bp_pending_a0", 32'(pending), 32'hA0);
    mask = 8'hFF;
    tick();
    check("bp_mask_valid", 32'(valid), 32'd1);
    check("bp_mask_code", 32'(code), 32'd5);
    mask  = 8'h00;
    ready = 1'b1;
    tick();
    check("bp_acc_valid", 32'(valid), 32'd0);
    check("bp_acc_pending", 32'(pending), 32'h80);
    tick();
    check("bp_code7_valid", 32'(valid), 32'd1);
    check("bp_code7", 32'(code), 32'd7);
    tick();
    check("bp_end_pending", 32'(pending), 32'h00);
    req = 8'h00;
    tick();

    // Mask blocks presentation but not capture
    mask = 8'h04;
    req  = 8'h04;
    tick();
    check("mask_pending", 32'(pending), 32'h04);
    tick();
    check("mask_valid0", 32'(valid), 32'd0);
    check("mask_pending_hold", 32'(pending), 32'h04);
    mask = 8'h00;
    tick();
    check("mask_valid1", 32'(valid), 32'd1);
    check("mask_code2", 32'(code), 32'd2);
    tick();
    check("mask_acc_pending", 32'(pending), 32'h00);
    req = 8'h00;
    tick();

    // Overflow: two pulses on bit 1 while stalled
    ready = 1'b0;
    req   = 8'h02;
    tick();
    check("ovf_first_pending", 32'(pending), 32'h02);
    check("ovf_clear", 32'(overflow), 32'd0);
    req = 8'h00;
    tick();
    check("ovf_code1", 32'(code), 32'd1);
    req = 8'h02;
    tick();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_pending", 32'(pending), 32'h02);
    req   = 8'h00;
    ready = 1'b1;
    tick();
    check("ovf_acc_valid", 32'(valid), 32'd0);
    check("ovf_acc_pending", 32'(pending), 32'h00);
    tick();
    check("ovf_one_grant", 32'(valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Event coinciding with acceptance keeps the bit pending
    ready = 1'b0;
    req   = 8'h02;
    tick();
    req = 8'h00;
    tick();
    check("coin_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    req   = 8'h02;
    tick();
    check("coin_pending", 32'(pending), 32'h02);
    check("coin_bubble", 32'(valid), 32'd0);
    req = 8'h00;
    tick();
    check("coin_regrant", 32'(valid), 32'd1);
    check("coin_code1", 32'(code), 32'd1);
    tick();
    check("coin_end_pending", 32'(pending), 32'h00);

    // Reset mid-handshake
    ready = 1'b0;
    req   = 8'h08;
    tick();
    tick();
    check("midrst_valid_pre", 32'(valid), 32'd1);
    check("midrst_code_pre", 32'(code), 32'd3);
    rst_n = 1'b0;
    tick();
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_code", 32'(code), 32'd0);
    check("midrst_pending", 32'(pending), 32'h00);
    check("midrst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_rel_pending", 32'(pending), 32'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
